// File: rtl/rom_program_loader.sv
// Frame-driven writer for the instruction ROM: parses SYNC/LEN/data/CSUM byte frames,
// strobes one ROM write per word, and holds the CPU in reset until a frame checks out.
module rom_program_loader #(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
  parameter int unsigned BOOT_ADDR  = 0
) (
  input  logic                  CLK,
  input  logic                  reset_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  rom_wr_en,
  output logic [ADDR_WIDTH-1:0] rom_wr_addr,
  output logic [15:0]           rom_wr_data,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM, DONE, ERR
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] BOOT      = ADDR_WIDTH'(BOOT_ADDR);
  localparam logic [31:0]           MAX_WORDS = 32'd1 << ADDR_WIDTH;

  state_t                state, state_nxt;
  logic [7:0]            len_hi, len_hi_nxt;
  logic [7:0]            hi, hi_nxt;
  logic [7:0]            csum, csum_nxt;
  logic [15:0]           len, len_nxt;
  logic [15:0]           index, index_nxt;
  logic                  wr_en_nxt, cpu_reset_nxt, done_nxt, error_nxt;
  logic [ADDR_WIDTH-1:0] wr_addr_nxt;
  logic [15:0]           wr_data_nxt;

  logic        accept;
  logic        is_sync;
  logic [15:0] n_in;
  logic [7:0]  csum_add;

  assign accept   = rx_valid & rx_ready;
  assign is_sync  = (rx_data == SYNC_BYTE);
  assign n_in     = {len_hi, rx_data};
  assign csum_add = csum + rx_data;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      len_hi      <= '0;
      hi          <= '0;
      csum        <= '0;
      len         <= '0;
      index       <= '0;
      rx_ready    <= 1'b0;
      rom_wr_en   <= 1'b0;
      rom_wr_addr <= '0;
      rom_wr_data <= '0;
      cpu_reset   <= 1'b1;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      state       <= state_nxt;
      len_hi      <= len_hi_nxt;
      hi          <= hi_nxt;
      csum        <= csum_nxt;
      len         <= len_nxt;
      index       <= index_nxt;
      rx_ready    <= 1'b1;
      rom_wr_en   <= wr_en_nxt;
      rom_wr_addr <= wr_addr_nxt;
      rom_wr_data <= wr_data_nxt;
      cpu_reset   <= cpu_reset_nxt;
      done        <= done_nxt;
      error       <= error_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    len_hi_nxt    = len_hi;
    hi_nxt        = hi;
    csum_nxt      = csum;
    len_nxt       = len;
    index_nxt     = index;
    wr_en_nxt     = 1'b0;
    wr_addr_nxt   = rom_wr_addr;
    wr_data_nxt   = rom_wr_data;
    cpu_reset_nxt = cpu_reset;
    done_nxt      = done;
    error_nxt     = error;
    if (accept) begin
      case (state)
        IDLE, DONE, ERR: begin
          // Any sync outside a frame restarts loading and re-asserts CPU reset.
          if (is_sync) begin
            state_nxt     = LEN_HI;
            index_nxt     = '0;
            csum_nxt      = '0;
            done_nxt      = 1'b0;
            error_nxt     = 1'b0;
            cpu_reset_nxt = 1'b1;
          end
        end
        LEN_HI: begin
          len_hi_nxt = rx_data;
          state_nxt  = LEN_LO;
        end
        LEN_LO: begin
          len_nxt = n_in;
          if (n_in == '0) begin
            state_nxt = CSUM;
          end else if (32'(n_in) > MAX_WORDS) begin
            state_nxt     = ERR;
            error_nxt     = 1'b1;
            cpu_reset_nxt = 1'b1;
          end else begin
            state_nxt = DATA_HI;
          end
        end
        DATA_HI: begin
          hi_nxt    = rx_data;
          csum_nxt  = csum_add;
          state_nxt = DATA_LO;
        end
        DATA_LO: begin
          wr_en_nxt   = 1'b1;
          wr_addr_nxt = BOOT + ADDR_WIDTH'(index);
          wr_data_nxt = {hi, rx_data};
          index_nxt   = index + 16'd1;
          csum_nxt    = csum_add;
          state_nxt   = (index + 16'd1 == len) ? CSUM : DATA_HI;
        end
        CSUM: begin
          if (rx_data == csum) begin
            state_nxt     = DONE;
            done_nxt      = 1'b1;
            cpu_reset_nxt = 1'b0;
          end else begin
            state_nxt     = ERR;
            error_nxt     = 1'b1;
            cpu_reset_nxt = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule
